fighter_state_ctrl: RTL

//  Per-fighter gameplay controller sitting directly upstream of the sprite renderer. Turns debounced

---
 rtl/fighter_pkg.sv | 50 +++++
 rtl/fsc_combo_detector.sv | 55 +++++
 rtl/fighter_state_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared types for the fighter controller: character/move codes, combo states, button bundle.
package fighter_pkg;

    localparam int unsigned SCREEN_W      = 96;
    localparam int unsigned SCREEN_H      = 64;
    localparam int unsigned POS_W         = 7;
    localparam int unsigned VY_W          = 6;
    localparam int unsigned TIMER_W       = 8;
    localparam int unsigned INJURED_TICKS = 16;

    typedef enum logic [2:0] {
        CHAR_NORMAL  = 3'b000,
        CHAR_PUNCH   = 3'b001,
        CHAR_SP      = 3'b010,
        CHAR_INJURED = 3'b100
    } char_state_e;

    typedef enum logic [1:0] {
        MOVE_IDLE = 2'b00,
        MOVE_FWD  = 2'b01,
        MOVE_BACK = 2'b10
    } move_state_e;

    typedef enum logic [1:0] {
        CMB_C0    = 2'd0,
        CMB_C1    = 2'd1,
        CMB_C2    = 2'd2,
        CMB_ARMED = 2'd3
    } combo_state_e;

    typedef struct packed {
        logic left;
        logic right;
        logic up;
        logic down;
        logic attack;
    } btn_t;

    // Applies one tick's direction edges in left, down, right order.
    function automatic combo_state_e combo_step(input combo_state_e s, input logic l,
                                                input logic d, input logic r);
        combo_state_e n;
        n = s;
        if (l) n = CMB_C1;
        if (d) n = (n == CMB_C1) ? CMB_C2 : CMB_C0;
        if (r) n = (n == CMB_C2) ? CMB_ARMED : CMB_C0;
        return n;
    endfunction

endpackage

// File: rtl/fsc_combo_detector.sv
// Tracks the left > down > right special-move sequence; armed_c reflects this tick's evaluation.
module fsc_combo_detector
    import fighter_pkg::*;
#(
    parameter int unsigned COMBO_WIN = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic left_ev,
    input  logic down_ev,
    input  logic right_ev,
    input  logic consume,
    output logic armed_c
);

    localparam int unsigned IDLE_W = $clog2(COMBO_WIN + 1);

    combo_state_e      state_q, state_d, eval_c;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              expired_c, progress_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CMB_C0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
        end
    end

    // Timeout is applied before this tick's edges so a late input restarts from C0.
    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        eval_c     = state_q;
        expired_c  = 1'b0;
        progress_c = 1'b0;
        if (tick) begin
            expired_c  = (state_q != CMB_C0) && (idle_q >= IDLE_W'(COMBO_WIN));
            eval_c     = combo_step(expired_c ? CMB_C0 : state_q, left_ev, down_ev, right_ev);
            progress_c = (left_ev || down_ev || right_ev) && (eval_c != CMB_C0);
            if (progress_c)
                idle_d = '0;
            else if (idle_q < IDLE_W'(COMBO_WIN))
                idle_d = idle_q + IDLE_W'(1);
            state_d = eval_c;
        end
        if (consume)
            state_d = CMB_C0;
        armed_c = (eval_c == CMB_ARMED);
    end

endmodule

// File: rtl/fighter_state_ctrl.sv
// Per-fighter controller: buttons -> position, jump physics, attack state and facing for the renderer.
// Define FSC_HIT_STATE_EN to enable the INJURED state driven by hit_in.
module fighter_state_ctrl
    import fighter_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1_666_667,
    parameter int unsigned X_START     = 24,
    parameter int unsigned X_MIN       = 8,
    parameter int unsigned X_MAX       = 88,
    parameter int unsigned Y_GROUND    = 32,
    parameter int unsigned JUMP_V0     = 6,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned PUNCH_TICKS = 24,
    parameter int unsigned SP_TICKS    = 24,
    parameter int unsigned COMBO_WIN   = 30,
    parameter bit          MIRROR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_attack,
    input  logic [POS_W-1:0] opp_x,
    input  logic             hit_in,
    output logic [POS_W-1:0] x,
    output logic [POS_W-1:0] y,
    output logic             in_air,
    output logic [1:0]       move_state,
    output logic [2:0]       character_state,
    output logic             mirror
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned YN_W   = POS_W + 2;

    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                    tick_c;
    btn_t                    btn_c, btn_prev_q, btn_prev_d, edge_q, edge_d, ev_c;
    logic [POS_W-1:0]        x_q, x_d, y_q, y_d;
    logic                    in_air_q, in_air_d, mirror_q, mirror_d;
    logic signed [VY_W-1:0]  vy_q, vy_d;
    move_state_e             move_q, move_d;
    char_state_e             char_q, char_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic signed [YN_W-1:0]  y_next_c;
    logic                    armed_c, combo_clr_c, hit_c;
    logic                    normal_c, go_left_c, go_right_c;

    assign btn_c  = '{left: btn_left, right: btn_right, up: btn_up, down: btn_down, attack: btn_attack};
    assign ev_c   = edge_q | (btn_c & ~btn_prev_q);
    assign tick_c = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

`ifdef FSC_HIT_STATE_EN
    assign hit_c = hit_in && (char_q != CHAR_INJURED);
`else
    logic unused_hit_in;
    assign unused_hit_in = hit_in;
    assign hit_c         = 1'b0;
`endif

    assign combo_clr_c = (tick_c && ev_c.attack) || hit_c;

    fsc_combo_detector #(
        .COMBO_WIN (COMBO_WIN)
    ) u_combo (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_c),
        .left_ev  (ev_c.left),
        .down_ev  (ev_c.down),
        .right_ev (ev_c.right),
        .consume  (combo_clr_c),
        .armed_c  (armed_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
            btn_prev_q <= '0;
            edge_q     <= '0;
            x_q        <= POS_W'(X_START);
            y_q        <= POS_W'(Y_GROUND);
            in_air_q   <= 1'b0;
            vy_q       <= '0;
            move_q     <= MOVE_IDLE;
            char_q     <= CHAR_NORMAL;
            timer_q    <= '0;
            mirror_q   <= MIRROR_INIT;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            btn_prev_q <= btn_prev_d;
            edge_q     <= edge_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_air_q   <= in_air_d;
            vy_q       <= vy_d;
            move_q     <= move_d;
            char_q     <= char_d;
            timer_q    <= timer_d;
            mirror_q   <= mirror_d;
        end
    end

    // All tick updates read pre-tick state; latched edges are consumed on every tick.
    always_comb begin
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
        btn_prev_d = btn_c;
        edge_d     = tick_c ? '0 : ev_c;
        x_d        = x_q;
        y_d        = y_q;
        in_air_d   = in_air_q;
        vy_d       = vy_q;
        move_d     = move_q;
        char_d     = char_q;
        timer_d    = timer_q;
        mirror_d   = mirror_q;
        normal_c   = (char_q == CHAR_NORMAL);
        go_left_c  = btn_left && !btn_right;
        go_right_c = btn_right && !btn_left;
        y_next_c   = YN_W'(y_q) - YN_W'(vy_q);

        if (tick_c) begin
            if (normal_c && (go_left_c || go_right_c))
                move_d = ((go_right_c && !mirror_q) || (go_left_c && mirror_q)) ? MOVE_FWD : MOVE_BACK;
            else
                move_d = MOVE_IDLE;

            if (normal_c && go_right_c && (x_q < POS_W'(X_MAX)))
                x_d = x_q + POS_W'(1);
            if (normal_c && go_left_c && (x_q > POS_W'(X_MIN)))
                x_d = x_q - POS_W'(1);

            if (normal_c && !in_air_q) begin
                if (opp_x < x_q)
                    mirror_d = 1'b1;
                else if (opp_x > x_q)
                    mirror_d = 1'b0;
            end

            // Attack edge in the same tick wins over a jump edge.
            if (in_air_q) begin
                if (y_next_c >= $signed(YN_W'(Y_GROUND))) begin
                    y_d      = POS_W'(Y_GROUND);
                    in_air_d = 1'b0;
                    vy_d     = '0;
                end else begin
                    y_d  = y_next_c[YN_W-1] ? '0 : y_next_c[POS_W-1:0];
                    vy_d = vy_q - VY_W'(GRAVITY);
                end
            end else if (ev_c.up && normal_c && !ev_c.attack) begin
                in_air_d = 1'b1;
                vy_d     = VY_W'(JUMP_V0);
            end

            if (normal_c) begin
                if (ev_c.attack) begin
                    char_d  = armed_c ? CHAR_SP : CHAR_PUNCH;
                    timer_d = armed_c ? TIMER_W'(SP_TICKS) : TIMER_W'(PUNCH_TICKS);
                end
            end else if (timer_q <= TIMER_W'(1)) begin
                char_d  = CHAR_NORMAL;
                timer_d = '0;
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end

        if (hit_c) begin
            char_d  = CHAR_INJURED;
            timer_d = TIMER_W'(INJURED_TICKS);
        end
    end

    assign x               = x_q;
    assign y               = y_q;
    assign in_air          = in_air_q;
    assign move_state      = move_q;
    assign character_state = char_q;
    assign mirror          = mirror_q;

endmodule
